// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus interface and baud generator:
// register addresses, status bit positions and the divisor-commit states.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int STAT_TBR = 0;
  localparam int STAT_RDA = 1;

  // DIV_IDLE: no low byte waiting; LOW_PEND: shadow_low holds a new low byte
  typedef enum logic {
    DIV_IDLE,
    LOW_PEND
  } div_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Down-counting baud tick generator. Emits a one-cycle enable every
// divisor+1 clocks; a load strobe restarts the count from a new divisor
// and suppresses the tick on that cycle.
module spart_baud_gen #(
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd324
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic             i_load,
  output logic             o_baud_en
);

  logic [DIV_W-1:0] r_count;
  logic             r_baud_en;

  // Count down to zero, tick and reload; a commit load takes priority over the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= DIV_RESET;
      r_baud_en <= 1'b0;
    end else if (i_load) begin
      r_count   <= i_divisor;
      r_baud_en <= 1'b0;
    end else if (r_count == '0) begin
      r_count   <= i_divisor;
      r_baud_en <= 1'b1;
    end else begin
      r_count   <= r_count - DIV_W'(1);
      r_baud_en <= 1'b0;
    end
  end

  assign o_baud_en = r_baud_en;

endmodule

// File: rtl/spart_bus_baud.sv
// Processor-bus side of the SPART: decodes chip select, direction and
// address, drives read data onto the shared databus, generates the TX load
// and RX acknowledge strobes, and owns the divisor with an atomic
// low-then-high commit sequence feeding the baud tick generator.
module spart_bus_baud
  import spart_pkg::*;
#(
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       tbr,
  input  logic       rda,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rx_ack,
  output logic       baud_en
);

  logic             w_rd;
  logic             w_wr;
  logic             w_wr_dbl;
  logic             w_wr_dbh;
  logic [7:0]       w_rd_data;
  logic [7:0]       w_status;
  logic [DIV_W-1:0] w_div_next;

  logic [DIV_W-1:0] r_divisor;
  logic [7:0]       r_shadow_low;
  div_state_t       r_state;
  logic [7:0]       r_tx_data;
  logic             r_tx_load;
  logic             r_rx_ack;

  assign w_rd     = iocs && iorw;
  assign w_wr     = iocs && !iorw;
  assign w_wr_dbl = w_wr && (ioaddr == ADDR_DBL);
  assign w_wr_dbh = w_wr && (ioaddr == ADDR_DBH);

  // Read mux; the divisor bytes always show the committed value, never the shadow
  always_comb begin
    w_status           = 8'h00;
    w_status[STAT_TBR] = tbr;
    w_status[STAT_RDA] = rda;
    w_rd_data          = 8'h00;
    case (ioaddr)
      ADDR_BUF:    w_rd_data = rx_data;
      ADDR_STATUS: w_rd_data = w_status;
      ADDR_DBL:    w_rd_data = r_divisor[7:0];
      ADDR_DBH:    w_rd_data = r_divisor[15:8];
      default:     w_rd_data = 8'h00;
    endcase
  end

  assign databus = w_rd ? w_rd_data : 8'hzz;

  // Divisor value after this cycle; a high-byte write pairs with the shadow if one is pending
  always_comb begin
    w_div_next = r_divisor;
    if (w_wr_dbh) begin
      if (r_state == LOW_PEND) begin
        w_div_next = {databus, r_shadow_low};
      end else begin
        w_div_next = {databus, r_divisor[7:0]};
      end
    end
  end

  // TX load and RX acknowledge strobes, one cycle after the qualifying access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data <= 8'h00;
      r_tx_load <= 1'b0;
      r_rx_ack  <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      r_rx_ack  <= w_rd && (ioaddr == ADDR_BUF) && rda;
      if (w_wr && (ioaddr == ADDR_BUF) && tbr) begin
        r_tx_data <= databus;
        r_tx_load <= 1'b1;
      end
    end
  end

  // Divisor commit FSM: low byte parks in the shadow, high byte commits both at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= DIV_IDLE;
      r_shadow_low <= 8'h00;
      r_divisor    <= DIV_RESET;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_wr_dbl) begin
            r_shadow_low <= databus;
            r_state      <= LOW_PEND;
          end else if (w_wr_dbh) begin
            r_divisor <= w_div_next;
          end
        end
        LOW_PEND: begin
          if (w_wr_dbl) begin
            r_shadow_low <= databus;
          end else if (w_wr_dbh) begin
            r_divisor <= w_div_next;
            r_state   <= DIV_IDLE;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign tx_data = r_tx_data;
  assign tx_load = r_tx_load;
  assign rx_ack  = r_rx_ack;

  spart_baud_gen #(
    .DIV_W    (DIV_W),
    .DIV_RESET(DIV_RESET)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .i_divisor(w_div_next),
    .i_load   (w_wr_dbh),
    .o_baud_en(baud_en)
  );

endmodule

// File: tb/tb_spart_bus_baud.sv
// Bench for spart_bus_baud: scenario tasks drive randomized bus traffic and
// compare the DUT against a register-level model of the divisor, TX byte
// and baud tick schedule.
module tb_spart_bus_baud;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic       tbDrive = 1'b0;
  logic [7:0] tbData = 8'h00;
  logic       tbr = 1'b1;
  logic       rda = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       rx_ack;
  logic       baud_en;

  int checkCount = 0;
  int passCount  = 0;
  int cyc;

  // Reference model state: committed divisor, tick anchor edge, shadow byte, last TX byte
  int         modelDiv;
  int         modelAnchor;
  int         modelShadow;
  bit         modelLowPend;
  logic [7:0] modelTx;

  assign databus = tbDrive ? tbData : 8'hzz;

  spart_bus_baud dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .tbr    (tbr),
    .rda    (rda),
    .rx_data(rx_data),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .rx_ack (rx_ack),
    .baud_en(baud_en)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; ticks fall on anchor + k*(divisor+1)
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task modelReset;
    modelDiv     = 324;
    modelAnchor  = 0;
    modelShadow  = 0;
    modelLowPend = 0;
    modelTx      = 8'h00;
  endtask

  task holdReset;
    @(negedge clk);
    #3;
    rst     = 1'b0;
    iocs    = 1'b0;
    iorw    = 1'b0;
    tbDrive = 1'b0;
  endtask

  task releaseReset;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task busWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    iocs    = 1'b1;
    iorw    = 1'b0;
    ioaddr  = addr;
    tbData  = data;
    tbDrive = 1'b1;
    @(negedge clk);
    iocs    = 1'b0;
    tbDrive = 1'b0;
    case (addr)
      ADDR_BUF: if (tbr) modelTx = data;
      ADDR_DBL: begin
        modelShadow  = data;
        modelLowPend = 1;
      end
      ADDR_DBH: begin
        modelDiv     = data * 256 + (modelLowPend ? modelShadow : modelDiv % 256);
        modelLowPend = 0;
        modelAnchor  = cyc;
      end
      default: ;
    endcase
  endtask

  task busRead(input logic [1:0] addr, output logic [7:0] val);
    @(negedge clk);
    iocs    = 1'b1;
    iorw    = 1'b1;
    ioaddr  = addr;
    tbDrive = 1'b0;
    #1 val = databus;
    @(negedge clk);
    iocs = 1'b0;
    iorw = 1'b0;
  endtask

  task test_reset;
    logic [7:0] v;
    logic       expBaud;
    holdReset();
    #1;
    checkCount++;
    if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data);
    else passCount++;
    checkCount++;
    if ({tx_load, rx_ack, baud_en} !== 3'b000)
      $display("[TB] FAIL reset_strobes: got %b expected 000", {tx_load, rx_ack, baud_en});
    else passCount++;
    tbr = 1'b1;
    rda = 1'b0;
    releaseReset();
    for (int i = 0; i < 660; i++) begin
      @(negedge clk);
      expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
      checkCount++;
      if (baud_en !== expBaud) $display("[TB] FAIL reset_period cyc=%0d: got %b expected %b", cyc, baud_en, expBaud);
      else passCount++;
    end
    busRead(ADDR_STATUS, v);
    checkCount++;
    if (v !== 8'h01) $display("[TB] FAIL reset_status: got %h expected 01", v);
    else passCount++;
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== 8'h44) $display("[TB] FAIL reset_dbl: got %h expected 44", v);
    else passCount++;
    busRead(ADDR_DBH, v);
    checkCount++;
    if (v !== 8'h01) $display("[TB] FAIL reset_dbh: got %h expected 01", v);
    else passCount++;
  endtask

  task test_divisor_commit;
    logic [7:0] v;
    logic [7:0] lo;
    logic       expBaud;
    int         window;
    for (int t = 0; t < 5; t++) begin
      lo = (t == 0) ? 8'h0F : 8'($urandom_range(0, 40));
      busWrite(ADDR_DBL, lo);
      busWrite(ADDR_DBH, 8'h00);
      window = 2 * (modelDiv + 1) + 3;
      for (int i = 0; i < window; i++) begin
        @(negedge clk);
        expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
        checkCount++;
        if (baud_en !== expBaud) $display("[TB] FAIL commit_period div=%0d cyc=%0d: got %b expected %b", modelDiv, cyc, baud_en, expBaud);
        else passCount++;
      end
      busRead(ADDR_DBL, v);
      checkCount++;
      if (v !== 8'(modelDiv % 256)) $display("[TB] FAIL commit_dbl: got %h expected %h", v, 8'(modelDiv % 256));
      else passCount++;
      busRead(ADDR_DBH, v);
      checkCount++;
      if (v !== 8'(modelDiv / 256)) $display("[TB] FAIL commit_dbh: got %h expected %h", v, 8'(modelDiv / 256));
      else passCount++;
    end
  endtask

  task test_shadow;
    logic [7:0] v;
    logic [7:0] lo;
    logic [7:0] oldLow;
    logic       expBaud;
    oldLow = 8'(modelDiv % 256);
    busWrite(ADDR_DBL, 8'h55);
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== oldLow) $display("[TB] FAIL shadow_read_dbl: got %h expected %h", v, oldLow);
    else passCount++;
    for (int i = 0; i < 2 * (modelDiv + 1) + 2; i++) begin
      @(negedge clk);
      expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
      checkCount++;
      if (baud_en !== expBaud) $display("[TB] FAIL shadow_period cyc=%0d: got %b expected %b", cyc, baud_en, expBaud);
      else passCount++;
    end
    busWrite(ADDR_DBH, 8'h00);
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== 8'h55) $display("[TB] FAIL shadow_commit55: got %h expected 55", v);
    else passCount++;
    lo = 8'($urandom_range(0, 255));
    busWrite(ADDR_DBL, 8'($urandom_range(0, 255)));
    busWrite(ADDR_DBL, lo);
    busWrite(ADDR_DBH, 8'h00);
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== lo) $display("[TB] FAIL shadow_overwrite: got %h expected %h", v, lo);
    else passCount++;
    busWrite(ADDR_DBH, 8'h01);
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== 8'(modelDiv % 256)) $display("[TB] FAIL idle_dbh_low: got %h expected %h", v, 8'(modelDiv % 256));
    else passCount++;
    busRead(ADDR_DBH, v);
    checkCount++;
    if (v !== 8'h01) $display("[TB] FAIL idle_dbh_high: got %h expected 01", v);
    else passCount++;
    busWrite(ADDR_DBL, 8'h00);
    busWrite(ADDR_DBH, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
      checkCount++;
      if (baud_en !== expBaud) $display("[TB] FAIL div_zero cyc=%0d: got %b expected %b", cyc, baud_en, expBaud);
      else passCount++;
    end
  endtask

  task test_tx;
    logic [7:0] d;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin
        tbr = 1'b1;
        d   = 8'hA5;
      end else if (t == 1) begin
        tbr = 1'b0;
        d   = 8'h3C;
      end else begin
        tbr = 1'($urandom_range(0, 1));
        d   = 8'($urandom_range(0, 255));
      end
      busWrite(ADDR_BUF, d);
      checkCount++;
      if (tx_load !== tbr) $display("[TB] FAIL tx_load t=%0d: got %b expected %b", t, tx_load, tbr);
      else passCount++;
      checkCount++;
      if (tx_data !== modelTx) $display("[TB] FAIL tx_data t=%0d: got %h expected %h", t, tx_data, modelTx);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (tx_load !== 1'b0) $display("[TB] FAIL tx_load_width t=%0d: got %b expected 0", t, tx_load);
      else passCount++;
    end
    tbr = 1'b1;
    busWrite(ADDR_STATUS, 8'hFF);
    checkCount++;
    if ({tx_load, tx_data} !== {1'b0, modelTx})
      $display("[TB] FAIL status_write: got %b/%h expected 0/%h", tx_load, tx_data, modelTx);
    else passCount++;
  endtask

  task test_rx;
    logic [7:0] v;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin
        rda     = 1'b1;
        rx_data = 8'hC3;
      end else begin
        rda     = 1'($urandom_range(0, 1));
        rx_data = 8'($urandom_range(0, 255));
      end
      tbr = 1'($urandom_range(0, 1));
      busRead(ADDR_BUF, v);
      checkCount++;
      if (v !== rx_data) $display("[TB] FAIL rx_read t=%0d: got %h expected %h", t, v, rx_data);
      else passCount++;
      checkCount++;
      if (rx_ack !== rda) $display("[TB] FAIL rx_ack t=%0d: got %b expected %b", t, rx_ack, rda);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (rx_ack !== 1'b0) $display("[TB] FAIL rx_ack_width t=%0d: got %b expected 0", t, rx_ack);
      else passCount++;
      busRead(ADDR_STATUS, v);
      checkCount++;
      if (v !== {6'b0, rda, tbr}) $display("[TB] FAIL status t=%0d: got %h expected %h", t, v, {6'b0, rda, tbr});
      else passCount++;
    end
  endtask

  task test_no_select;
    rda = 1'b1;
    tbr = 1'b1;
    @(negedge clk);
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = ADDR_STATUS;
    tbData  = 8'h00;
    tbDrive = 1'b1;
    #1;
    checkCount++;
    if (databus !== 8'h00) $display("[TB] FAIL nosel_databus: got %h expected 00", databus);
    else passCount++;
    @(negedge clk);
    iorw    = 1'b0;
    ioaddr  = ADDR_BUF;
    tbData  = 8'h99;
    @(negedge clk);
    tbDrive = 1'b0;
    checkCount++;
    if ({rx_ack, tx_load, tx_data} !== {1'b0, 1'b0, modelTx})
      $display("[TB] FAIL nosel_state: got %b%b/%h expected 00/%h", rx_ack, tx_load, tx_data, modelTx);
    else passCount++;
    rda = 1'b0;
  endtask

  task test_reset_mid;
    logic [7:0] v;
    logic       expBaud;
    tbr = 1'b1;
    busWrite(ADDR_BUF, 8'h7E);
    busWrite(ADDR_DBL, 8'($urandom_range(1, 255)));
    repeat (7) @(negedge clk);
    holdReset();
    #1;
    checkCount++;
    if ({tx_data, tx_load, rx_ack, baud_en} !== 11'd0)
      $display("[TB] FAIL mid_reset_outputs: got %h/%b%b%b expected 00/000", tx_data, tx_load, rx_ack, baud_en);
    else passCount++;
    releaseReset();
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
      checkCount++;
      if (baud_en !== expBaud) $display("[TB] FAIL mid_reset_period cyc=%0d: got %b expected %b", cyc, baud_en, expBaud);
      else passCount++;
    end
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== 8'h44) $display("[TB] FAIL mid_reset_dbl: got %h expected 44", v);
    else passCount++;
    busWrite(ADDR_DBH, 8'h00);
    busRead(ADDR_DBL, v);
    checkCount++;
    if (v !== 8'(modelDiv % 256)) $display("[TB] FAIL mid_reset_shadow: got %h expected %h", v, 8'(modelDiv % 256));
    else passCount++;
    for (int i = 0; i < 2 * (modelDiv + 1) + 2; i++) begin
      @(negedge clk);
      expBaud = (cyc > modelAnchor) && (((cyc - modelAnchor) % (modelDiv + 1)) == 0);
      checkCount++;
      if (baud_en !== expBaud) $display("[TB] FAIL mid_reset_commit cyc=%0d: got %b expected %b", cyc, baud_en, expBaud);
      else passCount++;
    end
  endtask

  initial begin
    modelReset();
    $display("[TB] starting spart_bus_baud bench");
    test_reset();
    test_divisor_commit();
    test_shadow();
    test_tx();
    test_rx();
    test_no_select();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
